// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: shares one external 16-bit ALU between two requesters.
// Round-robin grant, registered operands, single- or multi-cycle execution,
// and a response channel tagged with the owning requester id.
module alu_issue_arbiter #(
  parameter int DATA_W     = 16,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_op,
  output logic              rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              rsp_illegal,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  input  logic              alu_carry,
  input  logic              alu_neg,
  output logic              busy
);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_MUL = 4'b1000;
  // Counter holds MUL_CYCLES-1 at most; keep it at least one bit wide.
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Any encoding above MUL has no ALU meaning.
  function automatic logic f_op_illegal(input logic [3:0] op);
    return (op > OP_MUL);
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_grant;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [3:0]        r_alu_ctrl;
  logic              r_op_illegal;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_result;
  logic [3:0]        r_rsp_flags;
  logic              r_rsp_illegal;
  logic              r_busy;

  logic              w_grant;
  logic              w_accept;
  logic [1:0]        w_req_ready;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic [3:0]        w_sel_op;

  assign w_sel_a  = w_grant ? req1_a  : req0_a;
  assign w_sel_b  = w_grant ? req1_b  : req0_b;
  assign w_sel_op = w_grant ? req1_op : req0_op;

  // Next-state, round-robin grant and combinational request accept.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_accept    = 1'b0;
    w_req_ready = 2'b00;
    case (r_state)
      ST_IDLE: begin
        case (req_valid)
          2'b01:   w_grant = 1'b0;
          2'b10:   w_grant = 1'b1;
          2'b11:   w_grant = ~r_last_grant;
          default: w_grant = 1'b0;
        endcase
        if (req_valid != 2'b00) begin
          w_accept    = 1'b1;
          w_req_ready = w_grant ? 2'b10 : 2'b01;
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (r_count != CNT_W'(0)) begin
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        // Only the owner's ready bit completes the response.
        if (rsp_ready[r_rsp_id]) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand latch, execution counter, result capture and response bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant  <= 1'b1;
      r_count       <= CNT_W'(0);
      r_alu_a       <= {DATA_W{1'b0}};
      r_alu_b       <= {DATA_W{1'b0}};
      r_alu_ctrl    <= OP_NOP;
      r_op_illegal  <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_result  <= {DATA_W{1'b0}};
      r_rsp_flags   <= 4'b0000;
      r_rsp_illegal <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_alu_a      <= w_sel_a;
            r_alu_b      <= w_sel_b;
            r_op_illegal <= f_op_illegal(w_sel_op);
            // Illegal opcodes drive the ALU with NOP for the whole EXEC phase.
            r_alu_ctrl   <= f_op_illegal(w_sel_op) ? OP_NOP : w_sel_op;
            r_rsp_id     <= w_grant;
            r_last_grant <= w_grant;
            r_count      <= (w_sel_op == OP_MUL) ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(0);
            r_busy       <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (r_count != CNT_W'(0)) begin
            r_count <= r_count - CNT_W'(1);
          end else begin
            r_rsp_result  <= alu_result;
            r_rsp_flags   <= {alu_ovf, alu_carry, alu_neg, alu_zero};
            r_rsp_illegal <= r_op_illegal;
            r_rsp_valid   <= 1'b1;
            r_alu_ctrl    <= OP_NOP;
          end
        end
        ST_RESP: begin
          if (rsp_ready[r_rsp_id]) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = w_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_result  = r_rsp_result;
  assign rsp_flags   = r_rsp_flags;
  assign rsp_illegal = r_rsp_illegal;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_ctrl    = r_alu_ctrl;
  assign busy        = r_busy;

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
Shares the single 16-bit ALU between two requesters (fetch/branch unit and execute unit) using round-robin arbitration. Each request is accepted through a valid/ready handshake. The block registers the operands, drives the ALU for one cycle, or MUL_CYCLES cycles for multiply, then captures the result and flags. It returns them through a response handshake tagged with the requester id.

Parameters:
DATA_W, 16, operand/result width (must match ALU)
MUL_CYCLES, 4, cycles alu_ctrl is held at MUL before capture (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  per-requester request valid (bit0 = req0, bit1 = req1)
req_ready  out  2  per-requester accept, combinational
req0_a, req0_b  in  DATA_W each  req0 operands
req0_op  in  4  req0 ALU opcode
req1_a, req1_b  in  DATA_W each  req1 operands
req1_op  in  4  req1 ALU opcode
rsp_valid  out  1  response valid
rsp_ready  in  2  per-requester response accept
rsp_id  out  1  requester owning the response
rsp_result  out  DATA_W  captured result
rsp_flags  out  4  {overflow, carry, negative, zero} captured
rsp_illegal  out  1  opcode > 4'b1000
alu_a, alu_b  out  DATA_W  ALU operands (registered)
alu_ctrl  out  4  ALU control
alu_result  in  DATA_W  ALU result
alu_zero, alu_ovf, alu_carry, alu_neg  in  1 each  ALU flags
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Opcodes: NOP 0000, ADD 0001, SUB 0010, AND 0011, OR 0100, SHL 0101, SHR 0110, SLT 0111, MUL 1000. Any value above 1000 is illegal.
- Reset values: state=IDLE; last_grant=1, so req0 wins first; counter=0; alu_a=alu_b=0; alu_ctrl=0000; rsp_valid=0; rsp_id=0; rsp_result=0; rsp_flags=0; rsp_illegal=0; busy=0; req_ready=00.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is nonzero only in IDLE, and at most one bit is set.
  - Grant: if exactly one req_valid bit is set, grant it. If both are set, grant ~last_grant.
  - req_ready[g] = req_valid[g] for the granted requester g.
  - On accept: latch a, b, op into alu_a/alu_b/op_q; rsp_id<=g; last_grant<=g.
  - Load counter: MUL_CYCLES-1 if op==MUL, else 0. Go to EXEC.
- EXEC:
  - alu_ctrl=op_q, or NOP if illegal; alu_a/alu_b held stable.
  - If counter!=0: decrement it and stay in EXEC.
  - Else: capture alu_result, the four flags and the illegal bit into the rsp registers; go to RESP.
- alu_ctrl is 0000 in IDLE and RESP.
- RESP:
  - rsp_valid=1; rsp_* held stable.
  - When rsp_ready[rsp_id]=1: go to IDLE. No new accept in that same cycle.
  - rsp_ready[~rsp_id] is ignored.
- Latency, with accept at edge N:
  - Non-MUL: rsp_valid high from cycle N+2.
  - MUL: rsp_valid high from cycle N+1+MUL_CYCLES.
  - Minimum issue interval is 3 cycles.
- Illegal opcode: ALU is driven with NOP, so result=0 and zero=1; rsp_illegal=1; latency is the same as non-MUL.
- Requester obligation: hold operands and op stable while valid && !ready. The arbiter never grants a requester whose valid is low.
- Simultaneous request while busy: the request waits with ready=0. No queueing and no starvation, because round-robin alternates under continuous contention.
- Reset mid-operation (EXEC or RESP): the operation is dropped with no response, and all registers return to reset values immediately.

Test Plan:
1. req0 ADD a=0x7FFF b=0x0001, accept at cycle N -> rsp_valid at N+2; rsp_id=0; rsp_result=0x8000; overflow=1; negative=1; carry=0; zero=0.
2. After reset, both valid: req0 SUB 0x0005-0x0005 and req1 OR 0x00F0|0x000F -> req0 granted first with result 0x0000, zero=1. req1 is granted next with result 0x00FF. Both reasserted -> req0 granted (alternation).
3. MUL_CYCLES=4, req1 MUL 0x0012*0x0003 -> alu_ctrl=1000 for exactly 4 cycles; rsp_valid at N+5; rsp_result=0x0036; rsp_id=1.
4. Backpressure: rsp_ready=00 for 10 cycles after response -> rsp_valid, rsp_result and flags stable; req_ready=00 while req0 is pending. Asserting rsp_ready for the wrong id has no effect; the correct id completes and returns to IDLE.
5. Assert rst_n low during EXEC of a MUL -> busy=0, rsp_valid=0 asynchronously. No response after release. Next contention grants req0.
6. req0 op=4'b1111 a=0x1234 b=0x5678 -> alu_ctrl stays 0000; rsp_result=0; zero=1; rsp_illegal=1; latency 2.
